// File: rtl/blink_pkg.sv
// blink_pkg: default timing constants shared by the blinker and its dividers
package blink_pkg;
  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DEF_HALF1   = 1_000_000;
  localparam int unsigned DEF_HALF2   = 2_500_000;
  localparam int unsigned DEF_HALF3   = 5_000_000;
  localparam int unsigned DEF_CNT_W   = 32;
endpackage

// File: rtl/blink_divider.sv
// blink_divider: one square-wave channel, toggles led every HALF clk edges
//   clk   in  system clock, rising edge
//   reest in  async active-low reset
//   led   out registered square wave, period 2*HALF
module blink_divider
  import blink_pkg::*;
#(
  parameter int unsigned HALF  = DEF_HALF1,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reest,
  output logic led
);
  logic [CNT_W-1:0] cnt;
  // terminal count is HALF-1 so the counter never reaches HALF and never wraps
  always_ff @(posedge clk or negedge reest)
    if (!reest) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (cnt == CNT_W'(HALF - 1)) begin
      cnt <= '0;
      led <= ~led;
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/blink.sv
// blink: three independent free-running LED blinkers for a board heartbeat
//   clk   in  system clock, rising edge
//   reest in  async active-low reset
//   led1  out fastest blink (half-period HALF1)
//   led2  out medium blink  (half-period HALF2)
//   led3  out slowest blink (half-period HALF3)
module blink
  import blink_pkg::*;
#(
  parameter int unsigned HALF1 = DEF_HALF1,
  parameter int unsigned HALF2 = DEF_HALF2,
  parameter int unsigned HALF3 = DEF_HALF3,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reest,
  output logic led1,
  output logic led2,
  output logic led3
);
  blink_divider #(.HALF(HALF1), .CNT_W(CNT_W)) u_d1 (.clk(clk), .reest(reest), .led(led1));
  blink_divider #(.HALF(HALF2), .CNT_W(CNT_W)) u_d2 (.clk(clk), .reest(reest), .led(led2));
  blink_divider #(.HALF(HALF3), .CNT_W(CNT_W)) u_d3 (.clk(clk), .reest(reest), .led(led3));
endmodule

// File: tb/tb_blink.sv
// tb_blink: directed check of blink against an edge-count model of the three channels
module tb_blink;
  localparam int H1 = 4, H2 = 6, H3 = 10;
  localparam int C1 = 1, C2 = 2, C3 = 3;
  logic clk = 1'b0;
  logic reest = 1'b0;
  logic led1, led2, led3, c1, c2, c3;
  int k = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  blink #(.HALF1(H1), .HALF2(H2), .HALF3(H3), .CNT_W(8)) dut (
    .clk(clk), .reest(reest), .led1(led1), .led2(led2), .led3(led3));
  blink #(.HALF1(C1), .HALF2(C2), .HALF3(C3), .CNT_W(4)) dut_c (
    .clk(clk), .reest(reest), .led1(c1), .led2(c2), .led3(c3));
  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, k, act, exp);
    end
  endtask
  function automatic logic model(input int edges, input int half);
    return ((edges / half) % 2) == 1;
  endfunction
  task automatic compare_all();
    check("led1", led1, reest ? model(k, H1) : 1'b0);
    check("led2", led2, reest ? model(k, H2) : 1'b0);
    check("led3", led3, reest ? model(k, H3) : 1'b0);
    check("c_led1", c1, reest ? model(k, C1) : 1'b0);
    check("c_led2", c2, reest ? model(k, C2) : 1'b0);
    check("c_led3", c3, reest ? model(k, C3) : 1'b0);
  endtask
  task automatic tick();
    @(posedge clk);
    if (reest) k++;
    #1;
    compare_all();
  endtask
  initial begin
    for (int i = 0; i < 5; i++) tick();
    check("hold_led1", led1, 1'b0);
    reest = 1'b1;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      case (k)
        1: check("pin_c1_e1", c1, 1'b1);
        2: check("pin_c1_e2", c1, 1'b0);
        3: check("pin_led1_e3", led1, 1'b0);
        4: check("pin_led1_e4", led1, 1'b1);
        6: check("pin_led2_e6", led2, 1'b1);
        8: check("pin_led1_e8", led1, 1'b0);
        9: check("pin_led3_e9", led3, 1'b0);
        10: check("pin_led3_e10", led3, 1'b1);
        12: begin
          check("pin_led1_e12", led1, 1'b1);
          check("pin_led2_e12", led2, 1'b0);
        end
        20: check("pin_led3_e20", led3, 1'b0);
        24: begin
          check("pin_led1_e24", led1, 1'b0);
          check("pin_led2_e24", led2, 1'b0);
        end
        60: begin
          check("pin_led1_e60", led1, 1'b1);
          check("pin_led2_e60", led2, 1'b0);
          check("pin_led3_e60", led3, 1'b0);
        end
        default: ;
      endcase
    end
    #2 reest = 1'b0;
    #1 k = 0;
    compare_all();
    tick();
    reest = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    check("pin_led1_e13", led1, 1'b1);
    check("pin_led2_e13", led2, 1'b0);
    check("pin_led3_e13", led3, 1'b1);
    #2 reest = 1'b0;
    #1;
    check("async_led1", led1, 1'b0);
    check("async_led2", led2, 1'b0);
    check("async_led3", led3, 1'b0);
    k = 0;
    compare_all();
    tick();
    tick();
    reest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (k == 3) check("rel_led1_e3", led1, 1'b0);
      if (k == 4) check("rel_led1_e4", led1, 1'b1);
    end
    for (int i = 0; i < 30; i++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
